// File: rtl/burst_ram_pkg.sv
// Shared definitions for the burst RAM: state encoding, beat width,
// command encodings and the byte-mask merge helper.
package burst_ram_pkg;

    localparam int BEAT_WIDTH = 64;
    localparam int BEAT_BYTES = BEAT_WIDTH / 8;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE,
        READ_WAIT,
        READ
    } state_e;

    // A set mask bit keeps the old byte.
    function automatic logic [BEAT_WIDTH-1:0] merge_beat(
        input logic [BEAT_WIDTH-1:0] old_word,
        input logic [BEAT_WIDTH-1:0] new_word,
        input logic [BEAT_BYTES-1:0] mask
    );
        logic [BEAT_WIDTH-1:0] r;
        r = old_word;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            if (!mask[i]) begin
                r[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/burst_ram.sv
// Burst-oriented 64-bit RAM with an init phase, fixed-length write and
// read bursts, and a programmable first-beat read latency.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4,
    parameter int READ_LATENCY   = 3,
    parameter int INIT_CYCLES    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd,
    input  logic                      cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] addr,
    input  logic [BEAT_WIDTH-1:0]     wr_data,
    input  logic [BEAT_BYTES-1:0]     data_mask,
    output logic [BEAT_WIDTH-1:0]     rd_data,
    output logic                      rd_data_ready,
    output logic                      busy,
    output logic                      init_calib
);

    localparam int DEPTH = 1 << DEPTH_BITWIDTH;

    logic [BEAT_WIDTH-1:0] mem [DEPTH];

    state_e                    state_q;
    state_e                    state_d;
    logic [15:0]               init_cnt;
    logic [15:0]               beat_q;
    logic [15:0]               lat_q;
    logic [DEPTH_BITWIDTH-1:0] ptr_q;
    logic [DEPTH_BITWIDTH-1:0] wr_addr;
    logic                      accept;
    logic                      init_done;
    logic                      last_wr;
    logic                      wr_en;
    logic                      rd_en;
    logic [BEAT_WIDTH-1:0]     wr_word;
    logic [BEAT_WIDTH-1:0]     rd_word;

    always_comb begin
        accept    = (state_q == IDLE) && cmd_en;
        init_done = (init_cnt + 16'd1) >= 16'(INIT_CYCLES);
        last_wr   = (beat_q + 16'd1) >= 16'(BURST_COUNT);
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        wr_addr   = ptr_q;
        state_d   = state_q;
        unique case (state_q)
            INIT: begin
                if (init_done) state_d = IDLE;
            end
            IDLE: begin
                if (accept) begin
                    if (cmd == CMD_WRITE) begin
                        wr_en   = 1'b1;
                        wr_addr = addr;
                        state_d = (BURST_COUNT > 1) ? WRITE : IDLE;
                    end else begin
                        state_d = READ_WAIT;
                    end
                end
            end
            WRITE: begin
                wr_en = 1'b1;
                if (last_wr) state_d = IDLE;
            end
            READ_WAIT: begin
                if (lat_q >= 16'(READ_LATENCY)) begin
                    rd_en   = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                if (beat_q < 16'(BURST_COUNT)) rd_en = 1'b1;
                else state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    assign wr_word = merge_beat(mem[wr_addr], wr_data, data_mask);
    // Same-cycle write to the word being read forwards the new data.
    assign rd_word = (wr_en && wr_addr == ptr_q) ? wr_word : mem[ptr_q];
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= INIT;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data       <= '0;
            rd_data_ready <= 1'b0;
            init_calib    <= 1'b0;
            init_cnt      <= '0;
            beat_q        <= '0;
            lat_q         <= '0;
            ptr_q         <= '0;
        end else begin
            rd_data_ready <= rd_en;
            if (rd_en) rd_data <= rd_word;
            case (state_q)
                INIT: begin
                    init_cnt <= init_cnt + 16'd1;
                    if (init_done) init_calib <= 1'b1;
                end
                IDLE: begin
                    if (accept) begin
                        lat_q <= 16'd1;
                        if (cmd == CMD_WRITE) begin
                            beat_q <= 16'd1;
                            ptr_q  <= addr + DEPTH_BITWIDTH'(1);
                        end else begin
                            beat_q <= 16'd0;
                            ptr_q  <= addr;
                        end
                    end
                end
                WRITE: begin
                    beat_q <= beat_q + 16'd1;
                    ptr_q  <= ptr_q + DEPTH_BITWIDTH'(1);
                end
                READ_WAIT: begin
                    if (rd_en) begin
                        beat_q <= 16'd1;
                        ptr_q  <= ptr_q + DEPTH_BITWIDTH'(1);
                    end else begin
                        lat_q <= lat_q + 16'd1;
                    end
                end
                READ: begin
                    if (rd_en) begin
                        beat_q <= beat_q + 16'd1;
                        ptr_q  <= ptr_q + DEPTH_BITWIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
